nibble_deframer: RTL and testbench



---
 rtl/nibble_deframer_pkg.sv | 10 +
 rtl/nibble_fifo.sv | 44 ++++
 rtl/nibble_deframer.sv | 119 +++++++++++
 tb/tb_nibble_deframer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/nibble_deframer_pkg.sv
// Shared types and defaults for the serial nibble deframer.
package deframer_pkg;

   typedef enum logic [1:0] {HUNT, DATA, CHECK} dfr_state_t;

   typedef logic [3:0] nibble_t;

   localparam logic [3:0] DFLT_SYNC = 4'hA;

endpackage

// File: rtl/nibble_fifo.sv
// Circular nibble buffer; a full FIFO still accepts a push when a pop frees a slot the same cycle.
module nibble_fifo
   import deframer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    push,
   input  logic    pop,
   input  nibble_t din,
   output nibble_t dout,
   output logic    full,
   output logic    empty
);

   localparam int AW = $clog2(DEPTH);

   // Extra MSB on each pointer distinguishes full from empty when indices match.
   logic [AW:0] wptr, rptr;
   nibble_t     mem [DEPTH];
   logic        wr, rd;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign wr    = push && (!full || pop);
   assign rd    = pop && !empty;
   assign dout  = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr) wptr <= wptr + 1'b1;
         if (rd) rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/nibble_deframer.sv
// Hunts a serial stream for a sync word, assembles framed nibbles, checks the XOR check nibble
// and presents buffered nibbles in divide-by-4 windows.
module nibble_deframer
   import deframer_pkg::*;
#(
   parameter logic [3:0] SYNC_WORD     = DFLT_SYNC,
   parameter int         FRAME_NIBBLES = 4,
   parameter int         FIFO_DEPTH    = 4
) (
   input  logic       fast_clk,
   input  logic       reset,
   input  logic       sdin,
   input  logic       sdin_valid,
   input  logic       stall,
   output logic [3:0] data,
   output logic       data_valid,
   output logic [1:0] phase,
   output logic       locked,
   output logic       chk_err,
   output logic       overflow
);

   dfr_state_t state, state_n;
   logic [2:0] sr;
   logic [1:0] bitcnt, bitcnt_n;
   logic [3:0] nibcnt, nibcnt_n;
   nibble_t    chk, chk_n;
   nibble_t    nib, fifo_dout;
   logic       push, pop, chk_err_n, fifo_full, fifo_empty;

   assign nib    = {sr, sdin};
   assign pop    = (phase == 2'd3) && !fifo_empty && !stall;
   assign locked = (state == DATA) || (state == CHECK);

   nibble_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (fast_clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (nib),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge fast_clk) begin
      if (reset) begin
         state    <= HUNT;
         bitcnt   <= '0;
         nibcnt   <= '0;
         chk      <= '0;
         chk_err  <= 1'b0;
         sr       <= '0;
         phase    <= '0;
         data     <= '0;
         data_valid <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state   <= state_n;
         bitcnt  <= bitcnt_n;
         nibcnt  <= nibcnt_n;
         chk     <= chk_n;
         chk_err <= chk_err_n;
         phase   <= phase + 2'd1;
         if (sdin_valid) sr <= nib[2:0];
         // Output register only moves on the window boundary.
         if (phase == 2'd3) begin
            data_valid <= pop;
            if (pop) data <= fifo_dout;
         end
         if (push && fifo_full && !pop) overflow <= 1'b1;
      end
   end

   always_comb begin
      state_n   = state;
      bitcnt_n  = bitcnt;
      nibcnt_n  = nibcnt;
      chk_n     = chk;
      push      = 1'b0;
      chk_err_n = 1'b0;
      case (state)
         HUNT: begin
            if (sdin_valid && nib == SYNC_WORD) begin
               state_n  = DATA;
               bitcnt_n = '0;
               nibcnt_n = '0;
               chk_n    = '0;
            end
         end
         DATA: begin
            if (sdin_valid) begin
               if (bitcnt == 2'd3) begin
                  push     = 1'b1;
                  chk_n    = chk ^ nib;
                  nibcnt_n = nibcnt + 4'd1;
                  bitcnt_n = '0;
                  if (nibcnt_n == 4'(FRAME_NIBBLES)) state_n = CHECK;
               end else begin
                  bitcnt_n = bitcnt + 2'd1;
               end
            end
         end
         CHECK: begin
            if (sdin_valid) begin
               if (bitcnt == 2'd3) begin
                  chk_err_n = (nib != chk);
                  bitcnt_n  = '0;
                  state_n   = HUNT;
               end else begin
                  bitcnt_n = bitcnt + 2'd1;
               end
            end
         end
         default: state_n = HUNT;
      endcase
   end

endmodule

// File: tb/tb_nibble_deframer.sv
// Randomized bench: a bit-stream reference model feeds a scoreboard of expected output nibbles.
module tb_nibble_deframer;

   localparam logic [3:0] SYNC  = 4'hA;
   localparam int         NF    = 4;
   localparam int         DEPTH = 2;

   logic       fast_clk = 1'b0;
   logic       reset = 1'b1, sdin = 1'b0, sdin_valid = 1'b0, stall = 1'b0;
   logic [3:0] data;
   logic [1:0] phase;
   logic       data_valid, locked, chk_err, overflow;

   nibble_deframer #(.SYNC_WORD(SYNC), .FRAME_NIBBLES(NF), .FIFO_DEPTH(DEPTH)) dut (
      .fast_clk   (fast_clk),
      .reset      (reset),
      .sdin       (sdin),
      .sdin_valid (sdin_valid),
      .stall      (stall),
      .data       (data),
      .data_valid (data_valid),
      .phase      (phase),
      .locked     (locked),
      .chk_err    (chk_err),
      .overflow   (overflow)
   );

   always #5 fast_clk = ~fast_clk;

   int errors = 0, checks = 0;

   // Reference model: bit position within the frame drives everything.
   int  mph, mwin, mk, macc, mdata;
   bit  minf, mdv, mlock, merr, movf, started;
   int  mq[$];
   int  sb[$];

   always @(posedge fast_clk) begin
      int nb;
      bit pop;
      if (reset) begin
         mph = 0; mwin = 0; mk = 0; macc = 0; mdata = 0;
         minf = 0; mdv = 0; mlock = 0; merr = 0; movf = 0;
         mq.delete();
         sb.delete();
      end else begin
         pop = (mph == 3) && !stall && (mq.size() > 0);
         if (mph == 3) begin
            mdv = pop;
            if (pop) begin
               mdata = mq.pop_front();
               sb.push_back(mdata);
            end
         end
         mph  = (mph + 1) % 4;
         merr = 0;
         if (sdin_valid) begin
            nb   = ((mwin << 1) | int'(sdin)) & 15;
            mwin = nb;
            if (!minf) begin
               if (nb == int'(SYNC)) begin minf = 1; mk = 0; macc = 0; end
            end else begin
               mk++;
               if (mk % 4 == 0) begin
                  if (mk / 4 <= NF) begin
                     macc ^= nb;
                     if (mq.size() < DEPTH) mq.push_back(nb);
                     else movf = 1;
                  end else begin
                     merr = (nb != macc);
                     minf = 0;
                  end
               end
            end
         end
         mlock = minf;
      end
      started = 1;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: lockstep flags plus a scoreboard pop at the start of each valid window.
   always @(negedge fast_clk) begin
      if (started) begin
         check("phase",      8'(phase),      8'(mph));
         check("data_valid", 8'(data_valid), 8'(mdv));
         check("data",       8'(data),       8'(mdata));
         check("locked",     8'(locked),     8'(mlock));
         check("chk_err",    8'(chk_err),    8'(merr));
         check("overflow",   8'(overflow),   8'(movf));
         if (data_valid === 1'b1 && phase == 2'd0) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb_underflow: got data %0h with nothing expected at %0t", data, $time);
            end else begin
               check("sb_data", 8'(data), 8'(sb.pop_front()));
            end
         end
      end
   end

   int stall_mode = 0;   // 0 off, 1 held, 2 random
   int gap_pct    = 0;
   bit alt        = 0;

   task automatic cyc(input bit v, input bit b);
      @(negedge fast_clk);
      sdin_valid = v;
      sdin       = v ? b : 1'($urandom_range(0, 1));
      stall      = (stall_mode == 1) ? 1'b1 :
                   (stall_mode == 2) ? ($urandom_range(0, 99) < 30) : 1'b0;
   endtask

   task automatic tx(input bit b);
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) cyc(1'b0, 1'b0);
      cyc(1'b1, b);
      if (alt) cyc(1'b0, 1'b0);
   endtask

   task automatic tx_nib(input logic [3:0] n);
      for (int i = 3; i >= 0; i--) tx(n[i]);
   endtask

   task automatic tx_frame(input logic [15:0] w, input logic [3:0] c);
      tx_nib(SYNC);
      for (int i = 3; i >= 0; i--) tx_nib(w[i*4 +: 4]);
      tx_nib(c);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge fast_clk);
      reset = 1'b1; sdin_valid = 1'b0; stall = 1'b0;
      @(negedge fast_clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [15:0] w;
      logic [3:0]  c;
      logic [7:0]  noise;
      int          nn;
      repeat (3) @(negedge fast_clk);
      reset = 1'b0;

      tx_frame(16'h35C9, 4'h3);
      idle(16);
      tx_frame(16'h35C9, 4'h4);
      idle(16);

      // Noise ahead of the sync word, then an overlapping sync.
      noise = 8'b01101101;
      for (int i = 7; i >= 0; i--) tx(noise[i]);
      tx(1'b0);
      tx_frame(16'h1234, 4'h4);
      idle(8);
      tx(1'b1); tx(1'b0);
      tx_frame(16'hBEEF, 4'hB ^ 4'hE ^ 4'hE ^ 4'hF);
      idle(16);

      // Held stall with a 2-deep FIFO drops the last two nibbles.
      stall_mode = 1;
      tx_frame(16'h1234, 4'h4);
      stall_mode = 0;
      idle(20);
      do_reset();

      // Reset after two nibbles, then a clean frame.
      tx_nib(SYNC); tx_nib(4'h7); tx_nib(4'h8); tx(1'b1);
      do_reset();
      tx_frame(16'h35C9, 4'h3);
      idle(16);

      // Alternating valid.
      alt = 1;
      tx_frame(16'h35C9, 4'h3);
      alt = 0;
      idle(16);

      for (int f = 0; f < 30; f++) begin
         gap_pct    = $urandom_range(0, 3) * 15;
         stall_mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
         nn = $urandom_range(0, 6);
         for (int i = 0; i < nn; i++) tx(1'($urandom_range(0, 1)));
         w = 16'($urandom);
         c = w[15:12] ^ w[11:8] ^ w[7:4] ^ w[3:0];
         if ($urandom_range(0, 2) == 0) c = 4'($urandom);
         tx_frame(w, c);
         if ($urandom_range(0, 4) == 0) begin
            stall_mode = 0;
            do_reset();
         end
      end
      gap_pct = 0;
      stall_mode = 0;
      idle(40);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
